// File: rtl/parity_pkg.sv
// Shared types and constants for the parity framing datapath.
// line_level maps a transmitter state to the level it drives on the serial line.
package parity_pkg;

   localparam int DEF_DATA_W       = 4;
   localparam int DEF_CLKS_PER_BIT = 4;
   localparam int FRAME_BITS       = DEF_DATA_W + 3;
   localparam logic LINE_IDLE      = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   function automatic logic line_level(input state_t st, input logic data_bit, input logic parity_bit);
      logic lvl;
      case (st)
         START:   lvl = 1'b0;
         DATA:    lvl = data_bit;
         PARITY:  lvl = parity_bit;
         STOP:    lvl = LINE_IDLE;
         default: lvl = LINE_IDLE;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/parity_frame_tx_baud_tick.sv
// Bit-period divider: strobes o_bit_end on the last cycle of every serial bit.
// Held at zero while i_clear is high so the first bit after IDLE gets a full period.
module baud_tick #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   output logic o_bit_end
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] ONE  = CW'(1'b1);

   logic [CW-1:0] r_cnt;
   logic          w_wrap;

   assign w_wrap    = (r_cnt == LAST);
   assign o_bit_end = !i_clear && w_wrap;

   // Cycle counter within the current bit period.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= {CW{1'b0}};
      end else if (i_clear || w_wrap) begin
         r_cnt <= {CW{1'b0}};
      end else begin
         r_cnt <= r_cnt + ONE;
      end
   end

endmodule

// File: rtl/parity_frame_tx.sv
// Serial framer: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// tx_out is registered from the next-state view, so the line changes on the edge a state begins.
module parity_frame_tx
   import parity_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_parity,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx_out,
   output logic              busy,
   output logic              done
);

   localparam int BCW = $clog2(DATA_W + 1);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);
   localparam logic [BCW-1:0] BIT_ONE  = BCW'(1'b1);

   state_t            r_state;
   state_t            w_state_next;
   logic [DATA_W-1:0] r_shreg;
   logic [DATA_W-1:0] w_shreg_next;
   logic              r_parity;
   logic              w_parity_next;
   logic [BCW-1:0]    r_bit_cnt;
   logic [BCW-1:0]    w_bit_cnt_next;
   logic              r_tx;
   logic              w_tx_next;
   logic              w_clear;
   logic              w_bit_end;

   assign w_clear = (r_state == IDLE);

   baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_tick (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (w_clear),
      .o_bit_end(w_bit_end)
   );

   // Next-state, shift register and bit counter update.
   always_comb begin
      w_state_next   = r_state;
      w_shreg_next   = r_shreg;
      w_parity_next  = r_parity;
      w_bit_cnt_next = r_bit_cnt;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_state_next   = START;
               w_shreg_next   = in_data;
               w_parity_next  = in_parity;
               w_bit_cnt_next = {BCW{1'b0}};
            end else begin
               w_state_next = IDLE;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_state_next = DATA;
            end else begin
               w_state_next = START;
            end
         end
         DATA: begin
            if (w_bit_end) begin
               w_shreg_next   = r_shreg >> 1'b1;
               w_bit_cnt_next = r_bit_cnt + BIT_ONE;
               if (r_bit_cnt == LAST_BIT) begin
                  w_state_next = PARITY;
               end else begin
                  w_state_next = DATA;
               end
            end else begin
               w_state_next = DATA;
            end
         end
         PARITY: begin
            if (w_bit_end) begin
               w_state_next = STOP;
            end else begin
               w_state_next = PARITY;
            end
         end
         STOP: begin
            if (w_bit_end) begin
               w_state_next = IDLE;
            end else begin
               w_state_next = STOP;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
      w_tx_next = line_level(w_state_next, w_shreg_next[0], w_parity_next);
   end

   // State, datapath and line register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_shreg   <= {DATA_W{1'b0}};
         r_parity  <= 1'b0;
         r_bit_cnt <= {BCW{1'b0}};
         r_tx      <= LINE_IDLE;
      end else begin
         r_state   <= w_state_next;
         r_shreg   <= w_shreg_next;
         r_parity  <= w_parity_next;
         r_bit_cnt <= w_bit_cnt_next;
         r_tx      <= w_tx_next;
      end
   end

   assign in_ready = (r_state == IDLE);
   assign busy     = (r_state != IDLE);
   assign done     = (r_state == STOP) && w_bit_end;
   assign tx_out   = r_tx;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: default build (4 clocks/bit) and a 1 clock/bit build.
// Expected line activity comes from the frame layout {stop, parity, data, start}.
module tb_parity_frame_tx;
   import parity_pkg::*;

   localparam int CPB0      = 4;
   localparam int FRAME_CYC = FRAME_BITS * CPB0;

   logic       clk;
   logic       rst_n;
   logic [3:0] in_data;
   logic       in_parity;
   logic       in_valid;
   logic       in_ready;
   logic       tx_out;
   logic       busy;
   logic       done;
   logic [3:0] in_data1;
   logic       in_parity1;
   logic       in_valid1;
   logic       in_ready1;
   logic       tx_out1;
   logic       busy1;
   logic       done1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] data;
      logic       par;
      logic [6:0] frame;
   } vec_t;

   vec_t vecs[5];

   parity_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(CPB0)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_parity(in_parity),
      .in_valid(in_valid), .in_ready(in_ready), .tx_out(tx_out), .busy(busy), .done(done)
   );

   parity_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_parity(in_parity1),
      .in_valid(in_valid1), .in_ready(in_ready1), .tx_out(tx_out1), .busy(busy1), .done(done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] frame_of(input logic [3:0] d, input logic p);
      return {1'b1, p, d, 1'b0};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at the negedge of the first start-bit cycle; walks the whole frame and the idle cycle after.
   task automatic check_frame0(input logic [6:0] fr, input int pulse_at, input int pulse_len);
      for (int c = 0; c < FRAME_CYC; c++) begin
         chk("tx_bit", 32'(tx_out), 32'(fr[c / CPB0]));
         chk("busy_frame", 32'(busy), 32'd1);
         chk("ready_frame", 32'(in_ready), 32'd0);
         chk("done_pos", 32'(done), (c == FRAME_CYC - 1) ? 32'd1 : 32'd0);
         if (c == pulse_at) begin
            in_valid  = 1'b1;
            in_data   = 4'h5;
            in_parity = 1'b1;
         end
         if (c == pulse_at + pulse_len) in_valid = 1'b0;
         @(negedge clk);
      end
      chk("idle_tx", 32'(tx_out), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_ready", 32'(in_ready), 32'd1);
      chk("idle_done", 32'(done), 32'd0);
   endtask

   task automatic run_frame0(input logic [3:0] d, input logic p, input logic [6:0] fr);
      @(negedge clk);
      chk("ready_before", 32'(in_ready), 32'd1);
      in_data   = d;
      in_parity = p;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check_frame0(fr, -1, 0);
   endtask

   initial begin
      logic [6:0] fa;
      logic [6:0] fb;
      logic [6:0] rx;
      logic [3:0] d;
      logic       p;

      rst_n      = 1'b0;
      in_data    = 4'h9;
      in_parity  = 1'b0;
      in_valid   = 1'b1;
      in_data1   = 4'h0;
      in_parity1 = 1'b0;
      in_valid1  = 1'b0;

      vecs[0] = '{4'b1011, 1'b1, 7'b1110110};
      vecs[1] = '{4'h0,    1'b0, 7'b1000000};
      vecs[2] = '{4'hF,    1'b1, 7'b1111110};
      vecs[3] = '{4'h5,    1'b0, 7'b1001010};
      vecs[4] = '{4'hA,    1'b1, 7'b1110100};

      // Power-up reset held three cycles with a word already offered.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_tx", 32'(tx_out), 32'd1);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_done", 32'(done), 32'd0);
         chk("rst_ready", 32'(in_ready), 32'd1);
      end
      rst_n = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check_frame0(frame_of(4'h9, 1'b0), -1, 0);

      // Table of single frames.
      for (int v = 0; v < 5; v++) begin
         run_frame0(vecs[v].data, vecs[v].par, vecs[v].frame);
      end

      // Back-to-back frames with in_valid held high.
      fa = frame_of(4'h0, 1'b0);
      fb = frame_of(4'hF, 1'b0);
      @(negedge clk);
      chk("b2b_ready0", 32'(in_ready), 32'd1);
      in_data   = 4'h0;
      in_parity = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i <= 2 * FRAME_CYC; i++) begin
         @(negedge clk);
         if (i == 0) in_data = 4'hF;
         if (i < FRAME_CYC)       chk("b2b_tx", 32'(tx_out), 32'(fa[i / CPB0]));
         else if (i == FRAME_CYC) chk("b2b_tx_gap", 32'(tx_out), 32'd1);
         else                     chk("b2b_tx", 32'(tx_out), 32'(fb[(i - FRAME_CYC - 1) / CPB0]));
         chk("b2b_ready", 32'(in_ready), (i == FRAME_CYC) ? 32'd1 : 32'd0);
         chk("b2b_done", 32'(done), (i == FRAME_CYC - 1 || i == 2 * FRAME_CYC) ? 32'd1 : 32'd0);
         if (i == FRAME_CYC + 1) in_valid = 1'b0;
      end
      @(negedge clk);
      chk("b2b_end_busy", 32'(busy), 32'd0);

      // Word offered mid-frame then withdrawn: ignored.
      @(negedge clk);
      in_data   = 4'h3;
      in_parity = 1'b0;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check_frame0(frame_of(4'h3, 1'b0), 8, 4);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("nolose_tx", 32'(tx_out), 32'd1);
         chk("nolose_busy", 32'(busy), 32'd0);
      end

      // Reset pulse during data bit 2.
      fa = frame_of(4'b1011, 1'b1);
      @(negedge clk);
      in_data   = 4'b1011;
      in_parity = 1'b1;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 0; c < 14; c++) begin
         chk("abort_pre_tx", 32'(tx_out), 32'(fa[c / CPB0]));
         @(negedge clk);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_tx", 32'(tx_out), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready", 32'(in_ready), 32'd1);
      chk("abort_done", 32'(done), 32'd0);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         chk("abort_nodone", 32'(done), 32'd0);
         chk("abort_idle_tx", 32'(tx_out), 32'd1);
      end
      run_frame0(4'h6, 1'b0, frame_of(4'h6, 1'b0));

      // Random frames against the layout model.
      for (int r = 0; r < 6; r++) begin
         d = 4'($urandom_range(0, 15));
         p = 1'($urandom_range(0, 1));
         run_frame0(d, p, frame_of(d, p));
      end

      // One clock per bit: sweep all nibbles and deserialize.
      for (int v = 0; v < 16; v++) begin
         @(negedge clk);
         chk("cpb1_ready", 32'(in_ready1), 32'd1);
         in_data1   = 4'(v);
         in_parity1 = ^(4'(v));
         in_valid1  = 1'b1;
         @(negedge clk);
         in_valid1 = 1'b0;
         for (int k = 0; k < FRAME_BITS; k++) begin
            rx[k] = tx_out1;
            chk("cpb1_busy", 32'(busy1), 32'd1);
            chk("cpb1_done", 32'(done1), (k == FRAME_BITS - 1) ? 32'd1 : 32'd0);
            @(negedge clk);
         end
         chk("cpb1_idle_busy", 32'(busy1), 32'd0);
         chk("cpb1_idle_tx", 32'(tx_out1), 32'd1);
         chk("cpb1_start", 32'(rx[0]), 32'd0);
         chk("cpb1_data", 32'(rx[4:1]), 32'(v));
         chk("cpb1_parity", 32'(rx[5]), 32'(^(4'(v))));
         chk("cpb1_stop", 32'(rx[6]), 32'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
Serial frame transmitter that sits directly downstream of parity_generator. It accepts a data nibble plus the parity bit produced by the generator over a valid/ready handshake. It then shifts out a framed serial word: start bit, data LSB-first, parity bit, stop bit. This block is the line-side driver for the parity datapath. The matching receiver/checker is a later block.

Parameters:
DATA_W, 4, payload width in bits; matches the parity_generator data width.
CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx_out; legal range is 1 or greater.

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
in_data  input  DATA_W  payload to send.
in_parity  input  1  parity bit from parity_generator (even_parity or odd_parity, selected at integration).
in_valid  input  1  upstream has a word available.
in_ready  output  1  block can accept a word this cycle.
tx_out  output  1  serial line; idles high.
busy  output  1  a frame is in progress.
done  output  1  single-cycle pulse when the stop bit completes.

Behaviour:
- Reset: when rst_n=0 at a rising edge, the following apply on the next cycle:
  - state=IDLE
  - tx_out=1, busy=0, done=0, in_ready=1
  - bit counter=0, baud counter=0, shift register=0
- Reset mid-frame: the frame is aborted at that edge and tx_out returns to 1. No done pulse is issued.
- States are IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - in_ready=1 (combinational from state).
  - On in_valid && in_ready, latch in_data into the shift register and latch in_parity, then go to START.
  - in_ready=0 in every other state. Words offered while busy are not accepted and are not lost; upstream holds them.
- START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx_out=shreg[0]. After CLKS_PER_BIT cycles, shift right and increment the bit counter. After DATA_W bits, go to PARITY.
- PARITY: tx_out=latched parity for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx_out=1 for CLKS_PER_BIT cycles. On the last cycle, assert done=1 for exactly one cycle and go to IDLE.
- Output timing:
  - tx_out is registered. The first start-bit cycle is the cycle after the acceptance edge.
  - Frame length is exactly (DATA_W+3)*CLKS_PER_BIT cycles, which is 28 with defaults.
  - busy=1 from the cycle after acceptance through the cycle done is asserted.
- Back-to-back frames: in_ready rises the cycle after done. With in_valid held high, the next start bit begins one cycle after that, giving exactly one idle-high cycle between frames.
- Baud counter:
  - Width is max(1,$clog2(CLKS_PER_BIT)).
  - It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - With CLKS_PER_BIT=1, every state lasts one cycle.
- Bit counter:
  - Width is $clog2(DATA_W+1).
  - It is cleared on entry to START.
- The block does not check in_parity. It is transmitted verbatim.

Decomposition:
- Shared package parity_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP)
  - localparam FRAME_BITS = DATA_W+3
  - the idle line level constant (1'b1)
- One natural sub-module is baud_tick, a CLKS_PER_BIT divider producing a one-cycle bit_end strobe. It is cleared when the FSM leaves IDLE.
- The FSM and shift register remain in parity_frame_tx.

Test Plan:
1. Defaults, in_data=4'b1011, in_parity=1, one-cycle valid -> tx_out is 0,1,1,0,1,1,1, each held 4 cycles. done pulses exactly 28 cycles after the acceptance edge. busy is high for those 28 cycles.
2. in_valid held high with in_data=4'h0, in_parity=0, then 4'hF/0 -> two frames separated by exactly one tx_out=1 idle cycle. in_ready is high only on the two acceptance cycles.
3. in_valid pulsed mid-frame with in_data=4'h5 -> not accepted (in_ready=0). The current frame is unchanged. 4'h5 is sent only if valid is still high after done.
4. rst_n=0 for one cycle during the DATA state (bit 2) -> tx_out=1, busy=0, in_ready=1 the next cycle. No done pulse. A fresh word afterwards transmits cleanly.
5. CLKS_PER_BIT=1, DATA_W=4, sweep in_data 0..15 with in_parity=^in_data -> each frame is 7 cycles. A bench deserializer recovers every nibble and parity bit exactly.
6. Power-up with rst_n held low for 3 cycles and in_valid=1 -> tx_out stays 1 and nothing is accepted until the first cycle after rst_n rises.
